// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the memory-access pipeline stage.
//   memop_e  - memory op encoding driven on memop_i
//   state_e  - FSM states of mem_lsu
//   size_e   - access size decoded from a memop
//   helpers  - size, signedness, load/store class and 64-bit-only decode
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        MEMOP_NOP = 4'd0,
        MEMOP_LB  = 4'd1,
        MEMOP_LBU = 4'd2,
        MEMOP_LH  = 4'd3,
        MEMOP_LHU = 4'd4,
        MEMOP_LW  = 4'd5,
        MEMOP_LWU = 4'd6,
        MEMOP_LD  = 4'd7,
        MEMOP_SB  = 4'd8,
        MEMOP_SH  = 4'd9,
        MEMOP_SW  = 4'd10,
        MEMOP_SD  = 4'd11
    } memop_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    function automatic size_e memop_size(input logic [3:0] op);
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH:            return SIZE_H;
            MEMOP_LW, MEMOP_LWU, MEMOP_SW:            return SIZE_W;
            MEMOP_LD, MEMOP_SD:                       return SIZE_D;
            default:                                  return SIZE_B;
        endcase
    endfunction

    // Loads that sign-extend their extracted field.
    function automatic logic memop_signed(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LH, MEMOP_LW: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic memop_is_load(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU,
            MEMOP_LW, MEMOP_LWU, MEMOP_LD:           return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic memop_is_store(input logic [3:0] op);
        case (op)
            MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SD: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Ops that only exist on a 64-bit datapath.
    function automatic logic memop_needs_64(input logic [3:0] op);
        case (op)
            MEMOP_LWU, MEMOP_LD, MEMOP_SD: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational lane steering for mem_lsu.
//   memop_i       op being aligned (new request or the latched one)
//   addr_lo_i     low three byte-address bits
//   store_data_i  store source value, replicated across lanes
//   rdata_i       bus read data
//   sel_o         byte-lane enables for the addressed bytes
//   wdata_o       replicated store data
//   load_data_o   extracted and sign/zero-extended load value
//   misalign_o    access not naturally aligned for its size
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          memop_i,
    input  logic [2:0]          addr_lo_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W/8-1:0] sel_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   load_data_o,
    output logic                misalign_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    size_e             size;
    logic              sgn;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] rep_b;
    logic [DATA_W-1:0] rep_h;
    logic [DATA_W-1:0] rep_w;
    logic [NB-1:0]     base_sel;

    assign size    = memop_size(memop_i);
    assign sgn     = memop_signed(memop_i);
    assign off     = addr_lo_i[OFF_W-1:0];
    // Bring the addressed byte down to lane 0 (little-endian lanes).
    assign shifted = rdata_i >> {off, 3'b000};

    // Store data is repeated so every lane of its size carries it;
    // the byte enables pick which lanes the memory actually writes.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign rep_b[8*gi +: 8] = store_data_i[7:0];
            assign rep_h[8*gi +: 8] = store_data_i[8*(gi%2) +: 8];
            assign rep_w[8*gi +: 8] = store_data_i[8*(gi%4) +: 8];
        end
    endgenerate

    always_comb begin
        base_sel    = '0;
        wdata_o     = store_data_i;
        misalign_o  = 1'b0;
        load_data_o = shifted;
        case (size)
            SIZE_B: begin
                base_sel[0]       = 1'b1;
                wdata_o           = rep_b;
                load_data_o       = {DATA_W{sgn & shifted[7]}};
                load_data_o[7:0]  = shifted[7:0];
            end
            SIZE_H: begin
                base_sel[1:0]     = 2'b11;
                wdata_o           = rep_h;
                misalign_o        = addr_lo_i[0];
                load_data_o       = {DATA_W{sgn & shifted[15]}};
                load_data_o[15:0] = shifted[15:0];
            end
            SIZE_W: begin
                base_sel[3:0]     = 4'hF;
                wdata_o           = rep_w;
                misalign_o        = (addr_lo_i[1:0] != 2'b00);
                load_data_o       = {DATA_W{sgn & shifted[31]}};
                load_data_o[31:0] = shifted[31:0];
            end
            default: begin
                base_sel          = '1;
                wdata_o           = store_data_i;
                misalign_o        = (addr_lo_i != 3'b000);
                load_data_o       = shifted;
            end
        endcase
    end

    assign sel_o = base_sel << off;

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access pipeline stage between execute and write-back.
//   clk, rst             clock, synchronous active-high reset
//   valid_i, memop_i     instruction present / its memory op
//   wd_i, wreg_i         destination register / write enable
//   wdata_i              ALU result for non-memory ops
//   mem_addr_i           effective byte address
//   store_data_i         store source value
//   stall_req_o          hold the upstream pipeline
//   wd_o, wreg_o,
//   wdata_o, err_o       registered write-back slot and error pulse
//   mem_req_o ... mem_wdata_o  registered bus request
//   mem_rdata_i, mem_ack_i     bus response
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            memop_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    output logic                  stall_req_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W/8-1:0]   mem_sel_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam bit WIDE  = (DATA_W == 64);
    // Count value of the last allowed wait cycle; no ack there means abort.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            lat_op_q;
    logic [2:0]            lat_addr_lo_q;
    logic [REG_ADDR_W-1:0] lat_wd_q;
    logic                  lat_wreg_q;

    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  err_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [NB-1:0]         mem_sel_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    logic [3:0]            al_op;
    logic [2:0]            al_addr_lo;
    logic [NB-1:0]         al_sel;
    logic [DATA_W-1:0]     al_wdata;
    logic [DATA_W-1:0]     al_load;
    logic                  al_misalign;

    logic                  is_load;
    logic                  is_store;
    logic                  supported;
    logic                  accept;
    logic                  timeout_hit;

    // While a bus access is outstanding the aligner works on the latched
    // request so the load extraction sees the original op and offset.
    assign al_op      = (state_q == BUS) ? lat_op_q      : memop_i;
    assign al_addr_lo = (state_q == BUS) ? lat_addr_lo_q : mem_addr_i[2:0];

    mem_lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .memop_i     (al_op),
        .addr_lo_i   (al_addr_lo),
        .store_data_i(store_data_i),
        .rdata_i     (mem_rdata_i),
        .sel_o       (al_sel),
        .wdata_o     (al_wdata),
        .load_data_o (al_load),
        .misalign_o  (al_misalign)
    );

    assign is_load     = memop_is_load(memop_i);
    assign is_store    = memop_is_store(memop_i);
    assign supported   = (is_load || is_store) && (WIDE || !memop_needs_64(memop_i));
    assign accept      = valid_i && supported && !al_misalign;
    assign timeout_hit = (cnt_q == TO_LAST);

    // Stall drops in the cycle the access resolves so the next instruction
    // is taken on the same edge that retires this one.
    assign stall_req_o = (state_q == IDLE) ? accept : !(mem_ack_i || timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lat_op_q      <= '0;
            lat_addr_lo_q <= '0;
            lat_wd_q      <= '0;
            lat_wreg_q    <= 1'b0;
            wd_q          <= '0;
            wreg_q        <= 1'b0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_sel_q     <= '0;
            mem_wdata_q   <= '0;
        end else begin
            // Slot defaults to a bubble; err_o is a single-cycle pulse.
            wreg_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (memop_i == MEMOP_NOP) begin
                            wd_q    <= wd_i;
                            wreg_q  <= wreg_i;
                            wdata_q <= wdata_i;
                        end else if (!accept) begin
                            // Unsupported or misaligned: consume the slot with an error.
                            err_q <= 1'b1;
                        end else begin
                            lat_op_q      <= memop_i;
                            lat_addr_lo_q <= mem_addr_i[2:0];
                            lat_wd_q      <= wd_i;
                            lat_wreg_q    <= wreg_i & is_load;
                            mem_req_q     <= 1'b1;
                            mem_we_q      <= is_store;
                            mem_addr_q    <= {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_sel_q     <= al_sel;
                            mem_wdata_q   <= al_wdata;
                            cnt_q         <= '0;
                            state_q       <= BUS;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                        wd_q      <= lat_wd_q;
                        wreg_q    <= lat_wreg_q;
                        if (memop_is_load(lat_op_q)) begin
                            wdata_q <= al_load;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign err_o       = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
